// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: special instruction words, PC increment
// and the fetch-stage state encoding.
package mips_pkg;

   localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
   localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
   localparam logic [31:0] PC_INC     = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's control, program-load and pipeline-latch signals.
// The master side is the debug/hazard/branch logic; the slave is the IF stage.
interface instruction_fetch_if #(
   parameter int ADDR_W = 8
);

   logic              i_step;
   logic              i_start;
   logic              i_wr_en;
   logic [ADDR_W-1:0] i_wr_addr;
   logic [31:0]       i_wr_data;
   logic              is_jump_taken;
   logic [31:0]       i_jump_addr;
   logic              is_write_pc;
   logic [31:0]       o_pc;
   logic [31:0]       o_instruction;
   logic              os_stop_pipe;
   logic              o_halted;
   logic [31:0]       o_pc_current;

   modport master (
      output i_step, i_start, i_wr_en, i_wr_addr, i_wr_data,
             is_jump_taken, i_jump_addr, is_write_pc,
      input  o_pc, o_instruction, os_stop_pipe, o_halted, o_pc_current
   );

   modport slave (
      input  i_step, i_start, i_wr_en, i_wr_addr, i_wr_data,
             is_jump_taken, i_jump_addr, is_write_pc,
      output o_pc, o_instruction, os_stop_pipe, o_halted, o_pc_current
   );

endinterface

// File: rtl/instruction_fetch_instr_mem.sv
// Instruction memory: one synchronous write port for program loading and one
// asynchronous read port for fetch. Contents are never reset.
module instr_mem #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_addr,
   input  logic [31:0]       i_wr_data,
   input  logic [ADDR_W-1:0] i_rd_addr,
   output logic [31:0]       o_rd_data
);

   logic [31:0] mem [MEM_DEPTH];

   // Program load: a written word becomes readable the cycle after the edge
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage of the five-stage MIPS pipeline: program counter, instruction
// memory, HALT detection and the combinational feed to the IF/ID latch.
module instruction_fetch
   import mips_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = 8
) (
   input logic                clk,
   input logic                rst,
   instruction_fetch_if.slave bus
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  fetched;
   logic [31:0]  jump_target;
   logic         fetched_is_halt;
   logic         mem_we;

   // Loading is only allowed while idle so a running program cannot be corrupted
   assign mem_we = bus.i_wr_en && (state == IDLE);

   instr_mem #(
      .MEM_DEPTH (MEM_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_instr_mem (
      .clk       (clk),
      .i_wr_en   (mem_we),
      .i_wr_addr (bus.i_wr_addr),
      .i_wr_data (bus.i_wr_data),
      .i_rd_addr (pc[ADDR_W+1:2]),
      .o_rd_data (fetched)
   );

   // Targets are word aligned; the low byte-offset bits are dropped
   assign jump_target     = bus.i_jump_addr & ~32'h3;
   assign fetched_is_halt = (fetched == HALT_INSTR);

   // PC and state machine; everything advances only on stepped cycles
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         pc    <= 32'h0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (bus.i_step) begin
                  if (bus.is_jump_taken) begin
                     pc <= jump_target;
                  end else if (!bus.is_write_pc) begin
                     pc <= pc;
                  end else if (fetched_is_halt) begin
                     state <= HALT;
                  end else begin
                     pc <= pc + PC_INC;
                  end
               end
            end
            HALT: begin
               if (bus.i_step && bus.is_jump_taken) begin
                  pc    <= jump_target;
                  state <= RUN;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_pc          = pc + PC_INC;
   assign bus.o_instruction = (state == IDLE) ? NOP_INSTR : fetched;
   assign bus.os_stop_pipe  = (state == HALT) || ((state == RUN) && fetched_is_halt);
   assign bus.o_halted      = (state == HALT);
   assign bus.o_pc_current  = pc;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

IF stage of the five-stage MIPS pipeline: owns the program counter, the instruction memory and the HALT detection, and feeds the IF/ID pipeline latch with `o_pc`, `o_instruction` and `os_stop_pipe`. The debug unit loads the program while the stage is idle, starts execution, and advances it with `i_step` (continuous or single-step). Jump redirects come from the branch-resolution stage; stalls come from the hazard unit.

## Interface
- `MEM_DEPTH`, 256: instruction memory depth in 32-bit words (power of two).
- `ADDR_W`, 8: word-address width, equal to log2(`MEM_DEPTH`).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `i_step` in 1: advance enable; PC and state change only on cycles where it is high.
- `i_start` in 1: pulse; moves IDLE→RUN.
- `i_wr_en` in 1: program-load write strobe. Honoured in IDLE only.
- `i_wr_addr` in `ADDR_W`: load word address.
- `i_wr_data` in 32: load data.
- `is_jump_taken` in 1: redirect PC to `i_jump_addr`.
- `i_jump_addr` in 32: jump/branch target, byte address.
- `is_write_pc` in 1: low = stall (hold PC), from the hazard unit.
- `o_pc` out 32: PC+4 of the instruction presented.
- `o_instruction` out 32: fetched instruction.
- `os_stop_pipe` out 1: the instruction presented is HALT.
- `o_halted` out 1: the stage is in HALT state. Goes to the debug unit.
- `o_pc_current` out 32: raw PC register. Goes to the debug unit.

## Operation
- States:
  - IDLE: loading allowed.
  - RUN: fetching.
  - HALT: stopped on a HALT instruction.
- Reset values:
  - State: IDLE.
  - PC: 0.
  - `o_pc`: 4.
  - `o_instruction`: 0.
  - `os_stop_pipe`: 0.
  - `o_halted`: 0.
  - `o_pc_current`: 0.
  - Memory contents are not cleared by reset.
- IDLE:
  - `i_wr_en` writes `i_wr_data` to `mem[i_wr_addr]` at the clock edge.
  - `o_instruction` is forced to 0 (NOP) and `os_stop_pipe` to 0.
  - `i_start` moves to RUN. If `i_start` and `i_wr_en` occur in the same cycle, the write is performed and the state still moves to RUN.
  - `i_step` is ignored.
- RUN, on a cycle with `i_step` high, in priority order:
  1. `is_jump_taken`: PC ← {`i_jump_addr`[31:2], 2'b00}.
  2. `is_write_pc` low: PC is held.
  3. Fetched word == HALT (0xFFFFFFFF): state → HALT, PC is held.
  4. Otherwise PC ← PC+4.
- HALT:
  - PC is frozen and the HALT word stays presented.
  - `os_stop_pipe` = 1, `o_halted` = 1.
  - `is_jump_taken` with `i_step` loads the target and returns the state to RUN. The latch flushes the HALT in the same cycle.
- Outside IDLE, `i_wr_en` is ignored and memory is unchanged.
- Addressing:
  - Read word address = PC[`ADDR_W`+1:2]; upper bits are ignored, so the PC wraps modulo `MEM_DEPTH`×4.
  - PC+4 is a 32-bit add that wraps at 2^32.
- `os_stop_pipe` = (state==HALT) | (state==RUN & fetched==HALT).
- Reset mid-run returns the stage to IDLE with PC 0; the program in memory is kept.

## Timing
- Memory read is asynchronous. `o_instruction`, `o_pc` and `os_stop_pipe` are combinational from the PC register and state, valid in the same cycle the PC updates. The IF/ID latch captures them on the next edge.
- PC and state update on the rising edge of a cycle with `i_step`=1. Fetch latency: 1 cycle per instruction.
- A memory write is visible to a read on the cycle after the write edge.
- A jump takes effect on the edge it is sampled: the target instruction is presented in the following cycle.

## Structure
- The shared package `mips_pkg` holds:
  - `HALT_INSTR` = 32'hFFFF_FFFF.
  - `NOP_INSTR` = 32'h0.
  - `PC_INC` = 4.
  - The state encoding: IDLE=2'd0, RUN=2'd1, HALT=2'd2.
- Sub-module `instr_mem`: single write port, asynchronous read port, parameterised by `MEM_DEPTH`/`ADDR_W`. The PC, the FSM and the output muxing live in `instruction_fetch`.

## Test plan
- Load: write 0x20010005, 0x20020007 and 0xFFFFFFFF at addresses 0..2, pulse `i_start`, hold `i_step`=1 → instructions in that order; `o_pc` = 4, 8, 12; `os_stop_pipe` rises with the third word; `o_halted`=1; PC stays 8.
- Stall: in RUN at PC=4, drop `is_write_pc` for 2 stepped cycles → PC holds at 4 with the instruction unchanged, then resumes at 8.
- Jump priority: at PC=8 assert `is_jump_taken`=1, `is_write_pc`=0 and `i_jump_addr`=0x23 in the same step → PC=0x20.
- Step gating: in RUN with `i_step`=0 for 5 cycles → PC and outputs unchanged.
- HALT exit and write lockout: while halted, `i_wr_en` to addr 2 leaves memory unchanged; `is_jump_taken` with target 0 → state RUN, PC=0.
- Reset: reset mid-RUN at PC=0x10 → IDLE, PC 0, `o_pc`=4, `o_instruction`=0; the program is still intact after a new `i_start`.
